// File: rtl/chip_serial_responder.sv
// Chip end of the FPGA serial link: receives a config word, settles, runs one ADC conversion, returns the result MSB first.
// Word latch to adc_start is (settle_cfg+1)*SETTLE_UNIT+1 cycles; the result waits in WAIT_RDY until spi_fpga_wait is seen.
module chip_serial_responder #(
  parameter int WORD_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 8,
  parameter int BIT_SETTLE   = 4,
  parameter int ROTAT_LOCA   = 17,
  parameter int ADC_INT_LOCA = 16,
  parameter int ADC_BITS     = 18,
  parameter int SETTLE_UNIT  = 16,
  parameter int ADC_TIMEOUT  = 1024,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                  clk_ext,
  input  logic                  rstb_ext,
  input  logic                  spi_so2chip_flag,
  input  logic                  dout_2_chip,
  input  logic                  spi_fpga_wait,
  input  logic                  cont_mode,
  input  logic                  adc_done,
  input  logic [ADC_BITS-1:0]   adc_data,
  output logic                  spi_si4chip_ena,
  output logic                  din_4_chip,
  output logic                  adc_start,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic [BIT_SETTLE-1:0] settle_cfg,
  output logic [BIT_SETTLE-1:0] aux_cfg,
  output logic                  rotate,
  output logic                  adc_int,
  output logic                  cfg_valid,
  output logic                  adc_timeout_err
);

  localparam int SETTLE_MAX = (2 ** BIT_SETTLE) * SETTLE_UNIT;
  localparam int CNT_MAX0   = (SETTLE_MAX > ADC_TIMEOUT) ? SETTLE_MAX : ADC_TIMEOUT;
  localparam int CNT_MAX1   = (CNT_MAX0 > ADC_BITS) ? CNT_MAX0 : ADC_BITS;
  localparam int CNT_MAX    = (CNT_MAX1 > GAP_CYCLES) ? CNT_MAX1 : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_WAIT_ADC,
    S_WAIT_RDY,
    S_TX,
    S_GAP
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CNT_W-1:0]      settle_last;
  logic [WORD_WIDTH-1:0] rx_sr;
  logic                  flag_q;
  logic                  word_latch;
  logic [ADC_BITS-1:0]   tx_sr;
  logic                  cap_result;
  logic                  tx_shift;
  logic                  err_set;

  // The flag's falling edge closes a word; anything shifted in earlier has already fallen off the MSB.
  assign word_latch = flag_q & ~spi_so2chip_flag;

  always_ff @(posedge clk_ext or negedge rstb_ext) begin
    if (!rstb_ext) begin
      rx_sr      <= '0;
      flag_q     <= 1'b0;
      cfg_valid  <= 1'b0;
      pixel_addr <= '0;
      settle_cfg <= '0;
      aux_cfg    <= '0;
      rotate     <= 1'b0;
      adc_int    <= 1'b0;
    end else begin
      flag_q    <= spi_so2chip_flag;
      cfg_valid <= word_latch;
      if (spi_so2chip_flag)
        rx_sr <= {rx_sr[WORD_WIDTH-2:0], dout_2_chip};
      if (word_latch) begin
        pixel_addr <= rx_sr[ADDR_WIDTH-1:0];
        settle_cfg <= rx_sr[ADDR_WIDTH+BIT_SETTLE-1:ADDR_WIDTH];
        aux_cfg    <= rx_sr[ADDR_WIDTH+2*BIT_SETTLE-1:ADDR_WIDTH+BIT_SETTLE];
        rotate     <= rx_sr[ROTAT_LOCA];
        adc_int    <= rx_sr[ADC_INT_LOCA];
      end
    end
  end

  assign settle_last = CNT_W'((32'(settle_cfg) + 32'd1) * SETTLE_UNIT - 1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    cap_result = 1'b0;
    tx_shift   = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: cnt_nxt = '0;
      S_SETTLE: begin
        if (cnt == settle_last) begin
          state_nxt = S_CONV;
          cnt_nxt   = '0;
        end
      end
      S_CONV: begin
        state_nxt = S_WAIT_ADC;
        cnt_nxt   = '0;
      end
      S_WAIT_ADC: begin
        if (adc_done) begin
          cap_result = 1'b1;
          state_nxt  = S_WAIT_RDY;
          cnt_nxt    = '0;
        end else if (cnt == CNT_W'(ADC_TIMEOUT - 1)) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_RDY: begin
        cnt_nxt = '0;
        if (spi_fpga_wait)
          state_nxt = S_TX;
      end
      S_TX: begin
        tx_shift = 1'b1;
        if (cnt == CNT_W'(ADC_BITS - 1)) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          state_nxt = cont_mode ? S_CONV : S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // A new word overrides whatever the sequencer was doing this cycle.
    if (word_latch) begin
      state_nxt  = S_SETTLE;
      cnt_nxt    = '0;
      cap_result = 1'b0;
      tx_shift   = 1'b0;
      err_set    = 1'b0;
    end
  end

  always_ff @(posedge clk_ext or negedge rstb_ext) begin
    if (!rstb_ext) begin
      state           <= S_IDLE;
      cnt             <= '0;
      tx_sr           <= '0;
      adc_start       <= 1'b0;
      adc_timeout_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      adc_start <= (state == S_CONV) & ~word_latch;
      if (cap_result)
        tx_sr <= adc_data;
      else if (tx_shift)
        tx_sr <= {tx_sr[ADC_BITS-2:0], 1'b0};
      if (word_latch)
        adc_timeout_err <= 1'b0;
      else if (err_set)
        adc_timeout_err <= 1'b1;
    end
  end

  assign spi_si4chip_ena = (state == S_TX);
  assign din_4_chip      = (state == S_TX) & tx_sr[ADC_BITS-1];

endmodule
